// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-channel debounce state
// encoding and the default debounce length.
package button_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_PRESS_CHECK   = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_RELEASE_CHECK = 2'd3
    } btn_state_e;

    // Debounced level implied by a state: high once a press has been accepted.
    function automatic logic state_is_held(input btn_state_e s);
        return (s == ST_PRESSED) || (s == ST_RELEASE_CHECK);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, run-length counter and a
// four-state debounce FSM.
// Ports:
//   clk      - clock, all state on rising edge
//   reset    - synchronous active-high reset
//   raw_i    - asynchronous bouncing switch level, 1 = pressed
//   press_o  - registered one-cycle pulse when a press is accepted
//   held_o   - registered debounced pressed level
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o,
    output logic held_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             press_q;
    logic             press_d;
    logic             held_q;
    logic             held_d;

    // State register, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_RELEASED;
            count_q <= '0;
            press_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            count_q <= count_d;
            press_q <= press_d;
            held_q  <= held_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        press_d = 1'b0;

        unique case (state_q)
            ST_RELEASED: begin
                count_d = '0;
                if (sync2_q) begin
                    state_d = ST_PRESS_CHECK;
                    count_d = CNT_W'(1);
                end
            end
            ST_PRESS_CHECK: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASED;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    count_d = '0;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                count_d = '0;
                if (!sync2_q) begin
                    state_d = ST_RELEASE_CHECK;
                    count_d = CNT_W'(1);
                end
            end
            ST_RELEASE_CHECK: begin
                if (sync2_q) begin
                    // Release glitch: go back without a new pulse
                    state_d = ST_PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                count_d = '0;
            end
        endcase

        held_d = state_is_held(state_d);
    end

    assign press_o = press_q;
    assign held_o  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: synchronizes and debounces N bouncing
// switch inputs, giving a one-cycle press pulse and a debounced level each.
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - synchronous active-high reset
//   button_raw - N asynchronous switch levels, 1 = pressed
//   button     - N registered one-cycle press pulses (to the lamp toggle stage)
//   held       - N registered debounced pressed levels
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N               = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] button_raw,
    output logic [N-1:0] button,
    output logic [N-1:0] held
);

    // Channels are fully independent
    for (genvar i = 0; i < int'(N); i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (button_raw[i]),
            .press_o(button[i]),
            .held_o (held[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] button_raw;
    logic [N-1:0] button;
    logic [N-1:0] held;
    logic [N-1:0] lamp;

    int n_tests;
    int n_fail;

    // Reference model: raw samples delayed two edges, then a debounced level
    // that flips after D consecutive samples disagreeing with it.
    logic [N-1:0] m_p1, m_p2, m_level, m_pulse;
    int           m_run [N];

    button_conditioner #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .button_raw(button_raw),
        .button    (button),
        .held      (held)
    );

    // Lamp toggle stage driven straight from the press pulses
    always_ff @(posedge clk) begin
        if (reset) lamp <= '0;
        else       lamp <= lamp ^ button;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_level = '0; m_pulse = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic tick(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] seen;
        button_raw = raw;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            seen    = m_p2;
            m_p2    = m_p1;
            m_p1    = raw;
            m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                if (seen[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_level[i] = seen[i];
                        m_pulse[i] = seen[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic settle_released();
        for (int k = 0; k < 2 * D + 4; k++) begin
            tick('0, 1'b0);
            n_tests++;
            if (button !== m_pulse || held !== m_level) begin
                n_fail++;
                $display("FAIL settle k=%0d button=%b held=%b expected button=%b held=%b",
                         k, button, held, m_pulse, m_level);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(N'($urandom), 1'b1);
            n_tests++;
            if (button !== '0 || held !== '0 || lamp !== '0) begin
                n_fail++;
                $display("FAIL reset k=%0d button=%b held=%b lamp=%b expected all 0",
                         k, button, held, lamp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] exp_b, exp_h;
        settle_released();
        for (int k = 0; k < 12; k++) begin
            tick(5'b00001, 1'b0);
            exp_b = (k == D + 1) ? 5'b00001 : 5'b00000;
            exp_h = (k >= D + 1) ? 5'b00001 : 5'b00000;
            n_tests++;
            if (button !== exp_b || held !== exp_h) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d button=%b held=%b expected button=%b held=%b",
                         k, button, held, exp_b, exp_h);
            end
        end
        settle_released();
    endtask

    task automatic test_bounce();
        logic [N-1:0] seq [5] = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00010};
        int pulses, pulse_edge;
        pulses = 0; pulse_edge = -1;
        for (int k = 0; k < 20; k++) begin
            tick((k < 5) ? seq[k] : 5'b00010, 1'b0);
            if (button[1]) begin pulses++; pulse_edge = k; end
            n_tests++;
            if (button !== m_pulse || held !== m_level) begin
                n_fail++;
                $display("FAIL bounce edge=%0d button=%b held=%b expected button=%b held=%b",
                         k, button, held, m_pulse, m_level);
            end
        end
        n_tests++;
        if (pulses != 1 || pulse_edge != 4 + D + 1) begin
            n_fail++;
            $display("FAIL bounce_count pulses=%0d at edge %0d expected 1 at edge %0d",
                     pulses, pulse_edge, 4 + D + 1);
        end
        settle_released();
    endtask

    task automatic test_release_glitch();
        for (int k = 0; k < 10; k++) tick(5'b00100, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick((k < 2) ? 5'b00000 : 5'b00100, 1'b0);
            n_tests++;
            if (held !== 5'b00100 || button !== 5'b00000 || held !== m_level) begin
                n_fail++;
                $display("FAIL release_glitch edge=%0d button=%b held=%b expected button=00000 held=00100",
                         k, button, held);
            end
        end
        settle_released();
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_b, exp_h;
        int extra;
        extra = 0;
        for (int k = 0; k < 55; k++) begin
            tick(5'b11111, 1'b0);
            exp_b = (k == D + 1) ? 5'b11111 : 5'b00000;
            exp_h = (k >= D + 1) ? 5'b11111 : 5'b00000;
            if (k > D + 1 && button !== '0) extra++;
            n_tests++;
            if (button !== exp_b || held !== exp_h) begin
                n_fail++;
                $display("FAIL simultaneous edge=%0d button=%b held=%b expected button=%b held=%b",
                         k, button, held, exp_b, exp_h);
            end
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL auto_repeat extra_pulses=%0d expected 0", extra);
        end
        settle_released();
    endtask

    task automatic test_reset_mid_check();
        logic [N-1:0] exp_b;
        for (int k = 0; k < 3; k++) tick(5'b01000, 1'b0);
        tick(5'b01000, 1'b1);
        n_tests++;
        if (button !== '0 || held !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_check button=%b held=%b expected 00000 00000", button, held);
        end
        for (int k = 0; k < 10; k++) begin
            tick(5'b01000, 1'b0);
            exp_b = (k == D + 1) ? 5'b01000 : 5'b00000;
            n_tests++;
            if (button !== exp_b || held !== m_level) begin
                n_fail++;
                $display("FAIL post_reset_press edge=%0d button=%b held=%b expected button=%b held=%b",
                         k, button, held, exp_b, m_level);
            end
        end
        settle_released();
    endtask

    task automatic test_lamp_toggle();
        logic [N-1:0] exp_lamp;
        int ch;
        tick('0, 1'b1);
        exp_lamp = '0;
        for (int p = 0; p < 8; p++) begin
            ch = int'($urandom_range(0, N - 1));
            for (int k = 0; k < 2 * D + 4; k++) tick(N'(1) << ch, 1'b0);
            for (int k = 0; k < 2 * D + 4; k++) tick('0, 1'b0);
            exp_lamp[ch] = ~exp_lamp[ch];
            n_tests++;
            if (lamp !== exp_lamp) begin
                n_fail++;
                $display("FAIL lamp_toggle press=%0d ch=%0d lamp=%b expected %b",
                         p, ch, lamp, exp_lamp);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] lv;
        int rem [N];
        lv = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    lv[i]  = ~lv[i];
                    rem[i] = int'($urandom_range(1, 10));
                end
                rem[i]--;
            end
            tick(lv, ($urandom_range(0, 199) == 0));
            n_tests++;
            if (button !== m_pulse || held !== m_level) begin
                n_fail++;
                $display("FAIL random cycle=%0d raw=%b button=%b held=%b expected button=%b held=%b",
                         k, lv, button, held, m_pulse, m_level);
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        button_raw = '0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_check();
        test_lamp_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N, default 5, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a level change; legal range is 2 to 65535.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port button_raw, input, N bits, asynchronous bouncing switch levels, 1 = pressed.
REQ-006 SHALL have port button, output, N bits, one-cycle press pulse per channel; feeds the lamp toggle stage's button input directly.
REQ-007 SHALL have port held, output, N bits, debounced pressed level per channel.

Function
REQ-008 SHALL pass each button_raw bit through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-009 SHALL run an independent 4-state FSM per channel: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
REQ-010 RELEASED: sync2=1 -> PRESS_CHECK with count=1; otherwise stay.
REQ-011 PRESS_CHECK: sync2=0 -> RELEASED and count cleared, with no pulse (bounce rejected); sync2=1 and count=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise count increments.
REQ-012 PRESSED: sync2=0 -> RELEASE_CHECK with count=1; otherwise stay.
REQ-013 RELEASE_CHECK: sync2=1 -> PRESSED and count cleared; sync2=0 and count=DEBOUNCE_CYCLES-1 -> RELEASED; otherwise count increments.
REQ-014 button[i] SHALL be registered and high for exactly one cycle, on the edge where channel i enters PRESSED from PRESS_CHECK only; a return from RELEASE_CHECK SHALL NOT pulse.
REQ-015 held[i] SHALL be registered, 1 in PRESSED and RELEASE_CHECK, 0 in RELEASED and PRESS_CHECK.
REQ-016 Latency: if button_raw[i] is first sampled high at edge E and stays high, button[i] and held[i] SHALL rise after edge E+DEBOUNCE_CYCLES+1; release latency to held[i] falling SHALL be identical.
REQ-017 A raw pulse or gap lasting fewer than DEBOUNCE_CYCLES sampled cycles SHALL produce no output change.
REQ-018 A button held indefinitely SHALL produce exactly one pulse; no auto-repeat.
REQ-019 Channels SHALL be fully independent; simultaneous presses SHALL pulse in the same cycle.
REQ-020 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide, SHALL never wrap, and SHALL hold at zero in RELEASED and PRESSED.

Reset
REQ-021 While reset=1 at a rising edge: synchronizers, counts, button and held SHALL all be cleared to 0, and every FSM SHALL go to RELEASED.
REQ-022 Reset SHALL abort any check in progress with no pulse.
REQ-023 A button held high through reset release SHALL be treated as a fresh press: its pulse SHALL rise after post-reset edge DEBOUNCE_CYCLES+1.

Structure
REQ-024 The FSM state encoding and the DEBOUNCE_CYCLES default SHALL live in shared package button_pkg.
REQ-025 The per-channel synchronizer, counter and FSM SHALL be sub-module debounce_channel, instantiated N times via generate.

Verification
REQ-026 Reset then a clean press, DEBOUNCE_CYCLES=4: raw[0]=1 sampled at edge 0 -> button=5'b00001 for one cycle after edge 5, and held[0] stays 1 while raw stays high.
REQ-027 Bounce: raw[1] toggles 1,0,1,0 every cycle, then holds 1 -> exactly one button[1] pulse, 5 cycles after the final rising sample.
REQ-028 Release glitch: while pressed, raw[2]=0 for 2 cycles, then 1 -> held[2] stays 1 and no pulse.
REQ-029 Simultaneous press: raw=5'b11111 at the same edge -> button=5'b11111 for one cycle; press held for 50 cycles -> no further pulses.
REQ-030 Reset mid-check: raw[3] high, reset asserted at edge 3 -> no pulse, all outputs 0; raw[3] still high after reset deasserts -> pulse after post-reset edge 5.
REQ-031 End-to-end: drive the lamp toggle stage from button; each clean press of channel k -> lamp[k] toggles exactly once.
